cic_interpolator: RTL and testbench

- Cascaded integrator-comb interpolation filter. It is the transmit-side counterpart of the decimating cic_filter: comb section at the low input rate, zero-stuffing upsampler, then integrator section at the full clock rate.
- Single clock domain. The low-rate input slot is a phase-counter strobe, not a second clock.
- Accepts one DW-bit signed sample every R clocks and produces one DW-bit signed, gain-normalised sample every clock while enabled.

---
 rtl/cic_pkg.sv | 28 ++
 rtl/cic_interp_int.sv | 52 +++++
 rtl/cic_interpolator.sv | 160 ++++++++++++++++
 tb/tb_cic_interpolator.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
// Shared types, constants and helpers for the CIC interpolator.
package cic_pkg;

    localparam int LOG2_MAX_R = 6;
    localparam int L2W        = $clog2(LOG2_MAX_R + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } cic_state_t;

    // Internal accumulator width: enough headroom for R^N growth at the largest ratio.
    function automatic int int_width(input int dw, input int n, input int log2_max_r);
        return dw + n * log2_max_r;
    endfunction

    // Ratio select to log2(R); R = 2^(os_sel+1), anything past the maximum clamps.
    function automatic logic [L2W-1:0] os_to_log2r(input logic [2:0] os_sel);
        logic [L2W-1:0] r;
        if (int'(os_sel) >= LOG2_MAX_R - 1) begin
            r = L2W'(LOG2_MAX_R);
        end else begin
            r = L2W'(int'(os_sel) + 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/cic_interp_int.sv
// N-stage registered integrator cascade running at the full clock rate.
// Sums wrap modulo 2^IW by design; the comb section cancels the wrap.
module cic_interp_int
    import cic_pkg::*;
#(
    parameter int IW = 34,
    parameter int N  = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clr_i,
    input  logic                 en_i,
    input  logic signed [IW-1:0] u_i,
    output logic signed [IW-1:0] out_o
);

    logic signed [IW-1:0] acc_q [N];
    logic signed [IW-1:0] acc_d [N];

    // Next accumulator values: clear wins, otherwise each stage adds its predecessor.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            acc_d[k] = acc_q[k];
        end
        if (clr_i) begin
            for (int k = 0; k < N; k++) begin
                acc_d[k] = '0;
            end
        end else if (en_i) begin
            acc_d[0] = acc_q[0] + u_i;
            for (int k = 1; k < N; k++) begin
                acc_d[k] = acc_q[k] + acc_q[k-1];
            end
        end
    end

    // Accumulator registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < N; k++) begin
                acc_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                acc_q[k] <= acc_d[k];
            end
        end
    end

    assign out_o = acc_q[N-1];

endmodule

// File: rtl/cic_interpolator.sv
// CIC interpolator: comb section at the input slot rate, zero-stuffing
// upsampler, integrator cascade at the clock rate, gain removed by shift.
//
// state | meaning
// IDLE  | datapath held at zero, ratio select sampled every cycle
// RUN   | phase counter running, one input slot per R cycles
module cic_interpolator
    import cic_pkg::*;
#(
    parameter int DW         = 16,
    parameter int N          = 3,
    parameter int LOG2_MAX_R = cic_pkg::LOG2_MAX_R
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [2:0]           os_sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] data_in,
    output logic                 out_valid,
    output logic signed [DW-1:0] data_out,
    output logic                 underrun
);

    localparam int IW  = int_width(DW, N, LOG2_MAX_R);
    localparam int WCW = $clog2(N + 2);

    cic_state_t state_q, state_d;

    logic [LOG2_MAX_R-1:0] phase_q, phase_d, phase_last;
    logic [L2W-1:0]        log2r_q, log2r_d;
    logic signed [DW-1:0]  x_q, x_d, x_cur;
    logic signed [IW-1:0]  dly_q [N];
    logic signed [IW-1:0]  dly_d [N];
    logic signed [IW-1:0]  comb_c [N+1];
    logic signed [IW-1:0]  comb_q, comb_d;
    logic                  ustb_q, ustb_d;
    logic [WCW-1:0]        warm_q, warm_d;
    logic                  out_valid_q, out_valid_d;
    logic signed [DW-1:0]  dout_q, dout_d;

    logic                  run_act;
    logic                  slot;
    logic                  accept;
    logic signed [IW-1:0]  u;
    logic signed [IW-1:0]  i_n;
    logic [7:0]            shamt;

    // Next-state logic: enable alone decides between running and idling.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable)  state_d = RUN;
            RUN:     if (!enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Slot decode, comb chain, upsampler and next values for all datapath registers.
    always_comb begin
        run_act    = (state_q == RUN) && enable;
        slot       = (state_q == RUN) && (phase_q == '0);
        accept     = slot && enable;
        phase_last = LOG2_MAX_R'((32'd1 << log2r_q) - 32'd1);

        // A missing sample on the slot repeats the previous one.
        x_cur     = (accept && in_valid) ? data_in : x_q;
        comb_c[0] = IW'(x_cur);
        for (int k = 1; k <= N; k++) begin
            comb_c[k] = comb_c[k-1] - dly_q[k-1];
        end

        u     = ustb_q ? comb_q : '0;
        shamt = 8'((N - 1) * int'(log2r_q));

        log2r_d = (state_q == IDLE) ? os_to_log2r(os_sel) : log2r_q;

        phase_d     = '0;
        x_d         = '0;
        comb_d      = '0;
        ustb_d      = 1'b0;
        warm_d      = '0;
        out_valid_d = 1'b0;
        dout_d      = '0;
        for (int k = 0; k < N; k++) begin
            dly_d[k] = '0;
        end

        if (run_act) begin
            phase_d = (phase_q == phase_last) ? '0 : phase_q + 1'b1;
            x_d     = x_cur;
            for (int k = 0; k < N; k++) begin
                dly_d[k] = accept ? comb_c[k] : dly_q[k];
            end
            comb_d      = accept ? comb_c[N] : comb_q;
            ustb_d      = accept;
            // Output is meaningful once the first slot has crossed the N+2 stage pipeline.
            warm_d      = (warm_q == WCW'(N + 1)) ? warm_q : warm_q + 1'b1;
            out_valid_d = (warm_q == WCW'(N + 1));
            dout_d      = DW'(i_n >>> shamt);
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q     <= '0;
            log2r_q     <= '0;
            x_q         <= '0;
            comb_q      <= '0;
            ustb_q      <= 1'b0;
            warm_q      <= '0;
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            for (int k = 0; k < N; k++) begin
                dly_q[k] <= '0;
            end
        end else begin
            phase_q     <= phase_d;
            log2r_q     <= log2r_d;
            x_q         <= x_d;
            comb_q      <= comb_d;
            ustb_q      <= ustb_d;
            warm_q      <= warm_d;
            out_valid_q <= out_valid_d;
            dout_q      <= dout_d;
            for (int k = 0; k < N; k++) begin
                dly_q[k] <= dly_d[k];
            end
        end
    end

    cic_interp_int #(
        .IW (IW),
        .N  (N)
    ) u_int (
        .clk_i (clk),
        .rst_i (reset),
        .clr_i (!run_act),
        .en_i  (run_act),
        .u_i   (u),
        .out_o (i_n)
    );

    assign in_ready  = slot;
    assign underrun  = accept && !in_valid;
    assign out_valid = out_valid_q;
    assign data_out  = dout_q;

endmodule

// File: tb/tb_cic_interpolator.sv
// Directed bench for the CIC interpolator with hand-computed expectations.
module tb_cic_interpolator;

    localparam int DW = 16;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 enable;
    logic [2:0]           os_sel;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] data_in;
    logic                 out_valid;
    logic signed [DW-1:0] data_out;
    logic                 underrun;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cic_interpolator #(
        .DW         (DW),
        .N          (3),
        .LOG2_MAX_R (6)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .os_sel    (os_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .out_valid (out_valid),
        .data_out  (data_out),
        .underrun  (underrun)
    );

    task automatic chk(input string tag, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Lands 2 time units after a rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Drop to IDLE, then request RUN with the given ratio and DC level; returns in cycle 0 of RUN.
    task automatic start_run(input logic [2:0] os, input logic signed [DW-1:0] d);
        enable = 1'b0;
        tick();
        os_sel   = os;
        data_in  = d;
        in_valid = 1'b1;
        enable   = 1'b1;
        tick();
        chk("start_in_ready", in_ready, 1);
    endtask

    // Called on a slot cycle; counts cycles to the next slot.
    task automatic period(input string tag, input int exp);
        int p;
        p = 0;
        do begin
            tick();
            p++;
        end while (!in_ready && p < 200);
        chk(tag, p, exp);
    endtask

    task automatic dc_check(input string tag, input int settle, input int exp);
        repeat (settle) tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            chk({tag, "_dout"}, data_out, exp);
            chk({tag, "_ov"}, out_valid, 1);
        end
    endtask

    int exp_imp [11] = '{0, 0, 0, 0, 0, 1024, 3072, 3072, 1024, 0, 0};

    initial begin
        int p;
        reset    = 1'b1;
        enable   = 1'b0;
        os_sel   = 3'd0;
        in_valid = 1'b0;
        data_in  = '0;

        tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_underrun", underrun, 0);
        tick();
        reset = 1'b0;
        tick();

        // Impulse at R=2: 4096 on the first slot then zeros.
        enable   = 1'b1;
        os_sel   = 3'd0;
        in_valid = 1'b1;
        data_in  = 16'sd4096;
        #1;
        chk("idle_in_ready", in_ready, 0);
        for (int k = 0; k <= 10; k++) begin
            tick();
            if (k == 1) data_in = '0;
            #1;
            chk($sformatf("imp_rdy[%0d]", k), in_ready, (k % 2 == 0) ? 1 : 0);
            chk($sformatf("imp_ov[%0d]", k), out_valid, (k >= 5) ? 1 : 0);
            chk($sformatf("imp_dout[%0d]", k), data_out, exp_imp[k]);
        end
        enable = 1'b0;
        tick();
        chk("stop_ov", out_valid, 0);
        chk("stop_dout", data_out, 0);
        chk("stop_rdy", in_ready, 0);

        // DC levels at the smallest and largest ratios.
        start_run(3'd0, 16'sd1000);
        period("r2_period", 2);
        dc_check("dc_r2", 20, 1000);

        start_run(3'd5, -16'sd32768);
        period("r64_period", 64);
        dc_check("dc_r64", 300, -32768);

        start_run(3'd7, -16'sd32768);
        period("os7_period", 64);
        dc_check("dc_os7", 300, -32768);

        // Underrun at R=4: one slot without a sample repeats the held value.
        start_run(3'd1, 16'sd500);
        period("r4_period", 4);
        dc_check("dc_r4", 40, 500);
        p = 0;
        while (!in_ready && p < 100) begin
            tick();
            p++;
        end
        chk("ur_find_slot", in_ready, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("ur_quiet", underrun, 0);
        end
        tick();
        in_valid = 1'b0;
        data_in  = -16'sd7;
        #1;
        chk("ur_rdy", in_ready, 1);
        chk("ur_pulse", underrun, 1);
        tick();
        in_valid = 1'b1;
        data_in  = 16'sd500;
        #1;
        chk("ur_after", underrun, 0);
        for (int k = 0; k < 16; k++) begin
            tick();
            chk("ur_dout", data_out, 500);
        end

        // Ratio change while running has no effect until the next IDLE.
        os_sel = 3'd2;
        p = 0;
        while (!in_ready && p < 100) begin
            tick();
            p++;
        end
        period("mode_hold_period", 4);
        // Enable falls on a slot with no sample: slot shown, no underrun.
        enable   = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("drop_rdy", in_ready, 1);
        chk("drop_ur", underrun, 0);
        tick();
        enable   = 1'b1;
        in_valid = 1'b1;
        #1;
        chk("drop_ov", out_valid, 0);
        chk("drop_dout", data_out, 0);
        chk("drop_rdy_idle", in_ready, 0);
        tick();
        chk("rerun_rdy", in_ready, 1);
        period("r8_period", 8);
        dc_check("dc_r8", 60, 500);

        // Asynchronous reset between edges.
        #1;
        reset = 1'b1;
        #1;
        chk("arst_dout", data_out, 0);
        chk("arst_ov", out_valid, 0);
        chk("arst_rdy", in_ready, 0);
        chk("arst_ur", underrun, 0);
        tick();
        reset = 1'b0;
        #1;
        chk("arst_idle_rdy", in_ready, 0);
        tick();
        chk("arst_c0_rdy", in_ready, 1);
        chk("arst_c0_dout", data_out, 0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("arst_ov[%0d]", k), out_valid, (k >= 5) ? 1 : 0);
            chk($sformatf("arst_rdy[%0d]", k), in_ready, (k == 8) ? 1 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, observed no end, expected end of test");
        $fatal(1);
    end

endmodule
